// File: rtl/game_match_ctrl.sv
// rtl/game_match_ctrl.sv - N-player match controller: splash, timed serve, play, pause, game over
// Optional win-by-two rule is enabled by defining MATCH_WIN_BY_TWO_EN.
module game_match_ctrl #(
    parameter int N_PLAYERS = 2,
    parameter int SCORE_W   = 3,
    parameter int WIN_SCORE = 5,
    parameter int SERVE_CYC = 50_000_000,
    parameter int CNT_W     = 26
) (
    input  logic                           clk,
    input  logic                           clr_n,
    input  logic                           start,
    input  logic                           pause,
    input  logic                           point,
    input  logic [1:0]                     point_idx,
    output logic [2:0]                     state,
    output logic [N_PLAYERS*SCORE_W-1:0]   scores,
    output logic [1:0]                     serve_idx,
    output logic                           launch,
    output logic [1:0]                     winner,
    output logic                           winner_valid
);

    typedef enum logic [2:0] {
        S_SPLASH = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSED = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_CYC - 1);

    // Assert asynchronously, release only after two clean clock edges.
    logic rst_meta, rst_n;
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    state_t                         st_q, st_d;
    logic [N_PLAYERS*SCORE_W-1:0]   scores_q, scores_d;
    logic [1:0]                     serve_q, serve_d;
    logic [CNT_W-1:0]               timer_q, timer_d;
    logic                           launch_q, launch_d;
    logic [1:0]                     winner_q, winner_d;
    logic                           wv_q, wv_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= S_SPLASH;
            scores_q <= '0;
            serve_q  <= 2'd0;
            timer_q  <= '0;
            launch_q <= 1'b0;
            winner_q <= 2'd0;
            wv_q     <= 1'b0;
        end else begin
            st_q     <= st_d;
            scores_q <= scores_d;
            serve_q  <= serve_d;
            timer_q  <= timer_d;
            launch_q <= launch_d;
            winner_q <= winner_d;
            wv_q     <= wv_d;
        end
    end

    logic               valid_pt;
    logic [SCORE_W-1:0] cur_score, new_score;
    logic               win;
`ifdef MATCH_WIN_BY_TWO_EN
    logic               lead_ok;
`endif

    always_comb begin
        valid_pt  = point && (int'(point_idx) < N_PLAYERS);
        cur_score = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (point_idx == 2'(i)) cur_score = scores_q[i*SCORE_W +: SCORE_W];
        end
        new_score = (cur_score == SCORE_MAX) ? cur_score : cur_score + 1'b1;
`ifdef MATCH_WIN_BY_TWO_EN
        // Must lead every opponent by two, unless the counter has topped out.
        lead_ok = 1'b1;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (point_idx != 2'(i) &&
                int'(new_score) < int'(scores_q[i*SCORE_W +: SCORE_W]) + 2)
                lead_ok = 1'b0;
        end
        win = (int'(new_score) >= WIN_SCORE && lead_ok) || (new_score == SCORE_MAX);
`else
        win = int'(new_score) >= WIN_SCORE;
`endif
    end

    always_comb begin
        st_d     = st_q;
        scores_d = scores_q;
        serve_d  = serve_q;
        timer_d  = timer_q;
        launch_d = 1'b0;
        winner_d = winner_q;
        wv_d     = wv_q;
        case (st_q)
            S_SPLASH: begin
                if (start) begin
                    st_d     = S_SERVE;
                    scores_d = '0;
                    serve_d  = 2'd0;
                    timer_d  = SERVE_LOAD;
                end
            end
            S_SERVE: begin
                if (timer_q == '0) begin
                    st_d     = S_PLAY;
                    launch_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_PLAY: begin
                // A valid point takes priority over a simultaneous pause.
                if (valid_pt) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (point_idx == 2'(i)) scores_d[i*SCORE_W +: SCORE_W] = new_score;
                    end
                    if (win) begin
                        st_d     = S_OVER;
                        winner_d = point_idx;
                        wv_d     = 1'b1;
                    end else begin
                        st_d    = S_SERVE;
                        serve_d = (int'(serve_q) == N_PLAYERS - 1) ? 2'd0 : serve_q + 2'd1;
                        timer_d = SERVE_LOAD;
                    end
                end else if (pause) begin
                    st_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (!pause) st_d = S_PLAY;
            end
            S_OVER: begin
                if (start) begin
                    st_d     = S_SERVE;
                    scores_d = '0;
                    serve_d  = 2'd0;
                    wv_d     = 1'b0;
                    timer_d  = SERVE_LOAD;
                end
            end
            default: st_d = S_SPLASH;
        endcase
    end

    assign state        = st_q;
    assign scores       = scores_q;
    assign serve_idx    = serve_q;
    assign launch       = launch_q;
    assign winner       = winner_q;
    assign winner_valid = wv_q;

endmodule

// File: tb/tb_game_match_ctrl.sv
// tb/tb_game_match_ctrl.sv - table-driven and directed checks for game_match_ctrl
module tb_game_match_ctrl;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0, pause = 1'b0, point = 1'b0;
    logic [1:0] point_idx = 2'd0;
    logic [2:0] state;
    logic [5:0] scores;
    logic [1:0] serve_idx, winner;
    logic       launch, winner_valid;

    logic       start3 = 1'b0, pause3 = 1'b0, point3 = 1'b0;
    logic [1:0] point_idx3 = 2'd0;
    logic [2:0] state3;
    logic [8:0] scores3;
    logic [1:0] serve_idx3, winner3;
    logic       launch3, winner_valid3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_match_ctrl #(.N_PLAYERS(2), .SCORE_W(3), .WIN_SCORE(5), .SERVE_CYC(4), .CNT_W(3)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .pause(pause), .point(point),
        .point_idx(point_idx), .state(state), .scores(scores), .serve_idx(serve_idx),
        .launch(launch), .winner(winner), .winner_valid(winner_valid)
    );

    game_match_ctrl #(.N_PLAYERS(3), .SCORE_W(3), .WIN_SCORE(5), .SERVE_CYC(4), .CNT_W(3)) dut3 (
        .clk(clk), .clr_n(clr_n), .start(start3), .pause(pause3), .point(point3),
        .point_idx(point_idx3), .state(state3), .scores(scores3), .serve_idx(serve_idx3),
        .launch(launch3), .winner(winner3), .winner_valid(winner_valid3)
    );

    typedef struct packed {
        logic       s_start;
        logic       s_pause;
        logic       s_point;
        logic [1:0] s_idx;
        logic [2:0] e_state;
        logic [5:0] e_scores;
        logic [1:0] e_serve;
        logic       e_launch;
        logic       e_wv;
        logic [1:0] e_winner;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic pa, input logic pt, input logic [1:0] pi,
                       input logic [2:0] es, input logic [5:0] esc, input logic [1:0] esv,
                       input logic el, input logic ewv, input logic [1:0] ew);
        vec_t v;
        v = '{st, pa, pt, pi, es, esc, esv, el, ewv, ew};
        vecs.push_back(v);
    endtask

    task automatic serve_rows(input logic [5:0] sc, input logic [1:0] sv);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 2'd0, 3'd1, sc, sv, 0, 0, 2'd0);
        add(0, 0, 0, 2'd0, 3'd2, sc, sv, 1, 0, 2'd0);
    endtask

    task automatic wait_play();
        int n = 0;
        while (state != 3'd2 && n < 20) begin
            tick();
            n++;
        end
        check("wait_play_timeout", int'(state), 2);
    endtask

    task automatic play_point(input logic [1:0] idx);
        wait_play();
        point = 1'b1;
        point_idx = idx;
        tick();
        point = 1'b0;
    endtask

    initial begin
        // Main flow: start, five points to player 1, restart, then pause behaviour.
        add(1, 0, 0, 2'd0, 3'd1, 6'd0, 2'd0, 0, 0, 2'd0);
        serve_rows(6'd0, 2'd0);
        for (int p = 1; p <= 5; p++) begin
            if (p < 5) begin
                add(0, 0, 1, 2'd1, 3'd1, 6'(p << 3), 2'(p % 2), 0, 0, 2'd0);
                serve_rows(6'(p << 3), 2'(p % 2));
            end else begin
                add(0, 0, 1, 2'd1, 3'd4, 6'(p << 3), 2'd0, 0, 1, 2'd1);
            end
        end
        add(0, 0, 0, 2'd0, 3'd4, 6'd40, 2'd0, 0, 1, 2'd1);
        add(1, 0, 0, 2'd0, 3'd1, 6'd0, 2'd0, 0, 0, 2'd0);
        serve_rows(6'd0, 2'd0);
        add(0, 1, 0, 2'd0, 3'd3, 6'd0, 2'd0, 0, 0, 2'd0);
        add(0, 1, 1, 2'd0, 3'd3, 6'd0, 2'd0, 0, 0, 2'd0);
        add(1, 1, 0, 2'd0, 3'd3, 6'd0, 2'd0, 0, 0, 2'd0);
        add(0, 0, 0, 2'd0, 3'd2, 6'd0, 2'd0, 0, 0, 2'd0);
        add(0, 1, 1, 2'd0, 3'd1, 6'd1, 2'd1, 0, 0, 2'd0);
        add(0, 1, 0, 2'd0, 3'd1, 6'd1, 2'd1, 0, 0, 2'd0);
        add(1, 0, 0, 2'd0, 3'd1, 6'd1, 2'd1, 0, 0, 2'd0);
        add(0, 0, 1, 2'd1, 3'd1, 6'd1, 2'd1, 0, 0, 2'd0);
        add(0, 0, 0, 2'd0, 3'd2, 6'd1, 2'd1, 1, 0, 2'd0);
        add(0, 0, 1, 2'd2, 3'd2, 6'd1, 2'd1, 0, 0, 2'd0);
        add(1, 0, 0, 2'd0, 3'd2, 6'd1, 2'd1, 0, 0, 2'd0);

        #2;
        check("rst_state", int'(state), 0);
        check("rst_scores", int'(scores), 0);
        check("rst_serve", int'(serve_idx), 0);
        check("rst_launch", int'(launch), 0);
        check("rst_wv", int'(winner_valid), 0);
        check("rst_winner", int'(winner), 0);
        tick();
        clr_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].s_start;
            pause = vecs[i].s_pause;
            point = vecs[i].s_point;
            point_idx = vecs[i].s_idx;
            tick();
            check($sformatf("v%0d_state", i), int'(state), int'(vecs[i].e_state));
            check($sformatf("v%0d_scores", i), int'(scores), int'(vecs[i].e_scores));
            check($sformatf("v%0d_serve", i), int'(serve_idx), int'(vecs[i].e_serve));
            check($sformatf("v%0d_launch", i), int'(launch), int'(vecs[i].e_launch));
            check($sformatf("v%0d_wv", i), int'(winner_valid), int'(vecs[i].e_wv));
            if (vecs[i].e_wv) check($sformatf("v%0d_winner", i), int'(winner), int'(vecs[i].e_winner));
        end
        start = 1'b0; pause = 1'b0; point = 1'b0; point_idx = 2'd0;

        // Reset in the middle of a serve.
        point = 1'b1; point_idx = 2'd1;
        tick();
        point = 1'b0;
        check("pre_rst_scores", int'(scores), 9);
        check("pre_rst_state", int'(state), 1);
        tick();
        clr_n = 1'b0;
        #1;
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_scores", int'(scores), 0);
        check("mid_rst_serve", int'(serve_idx), 0);
        check("mid_rst_launch", int'(launch), 0);
        check("mid_rst_wv", int'(winner_valid), 0);
        repeat (2) tick();
        clr_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", int'(state), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_rst_start", int'(state), 1);
        check("post_rst_scores", int'(scores), 0);

        // Build up to 4-4, then 5-4.
        for (int k = 0; k < 8; k++) play_point(2'(k % 2));
        check("tie44_scores", int'(scores), (4 << 3) | 4);
        play_point(2'd0);
        check("s54_scores", int'(scores), (4 << 3) | 5);
`ifdef MATCH_WIN_BY_TWO_EN
        check("s54_state", int'(state), 1);
        play_point(2'd0);
        check("s64_state", int'(state), 4);
        check("s64_scores", int'(scores), (4 << 3) | 6);
        check("s64_winner", int'(winner), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) play_point(2'(k % 2));
        play_point(2'd0);
        play_point(2'd1);
        check("s66_scores", int'(scores), (6 << 3) | 6);
        check("s66_state", int'(state), 1);
        play_point(2'd1);
        check("s67_scores", int'(scores), (7 << 3) | 6);
        check("s67_state", int'(state), 4);
        check("s67_winner", int'(winner), 1);
        check("s67_wv", int'(winner_valid), 1);
`else
        check("s54_state", int'(state), 4);
        check("s54_winner", int'(winner), 0);
        check("s54_wv", int'(winner_valid), 1);
`endif

        // Three-player instance: out-of-range index is dropped.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int n = 0; n < 20 && state3 != 3'd2; n++) tick();
        check("p3_play", int'(state3), 2);
        point3 = 1'b1; point_idx3 = 2'd3;
        tick();
        check("p3_bad_state", int'(state3), 2);
        check("p3_bad_scores", int'(scores3), 0);
        point_idx3 = 2'd2;
        tick();
        point3 = 1'b0;
        check("p3_state", int'(state3), 1);
        check("p3_scores", int'(scores3), 1 << 6);
        check("p3_serve", int'(serve_idx3), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_match_ctrl.md
# game_match_ctrl

Parametrised match controller for the multi-joystick VGA game. It generalises the fixed two-player splash/score flow to N players with a configurable win score and a timed serve delay. It also adds pause and an optional win-by-two rule. It sits between the button debouncers and the score display / VGA renderer, and owns the authoritative match state, scores, server and winner.

## Interface
Parameters:
- N_PLAYERS, 2, number of players (2..4)
- SCORE_W, 3, bits per player score
- WIN_SCORE, 5, points needed to win; must satisfy 1 <= WIN_SCORE <= 2^SCORE_W-1
- SERVE_CYC, 50_000_000, serve delay in clk cycles; must be >= 1
- CNT_W, 26, serve timer width; must satisfy 2^CNT_W > SERVE_CYC

Ports:
- clk  in  1  master clock (50 MHz)
- clr_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse from debouncer; starts or restarts the match
- pause  in  1  level; holds play while high
- point  in  1  single-cycle pulse; a point was scored
- point_idx  in  2  index of the scoring player, sampled when point=1
- state  out  3  SPLASH=0, SERVE=1, PLAY=2, PAUSED=3, OVER=4
- scores  out  N_PLAYERS*SCORE_W  packed scores; player i is at [i*SCORE_W +: SCORE_W]
- serve_idx  out  2  current serving player
- launch  out  1  one-cycle pulse when the ball is released
- winner  out  2  winning player index, valid when winner_valid=1
- winner_valid  out  1  high while in OVER

## Operation
- SPLASH: on start, go to SERVE. Clear all scores, set serve_idx=0, load timer=SERVE_CYC-1.
- SERVE: the timer decrements every cycle.
  - When the timer reads 0, go to PLAY and pulse launch.
  - point, pause and start are ignored in this state.
- PLAY, on a valid point (point=1 and point_idx<N_PLAYERS):
  - Increment scores[point_idx], saturating at 2^SCORE_W-1.
  - If the win condition holds on the new score: go to OVER, set winner=point_idx, set winner_valid=1.
  - Otherwise: go to SERVE, set serve_idx=(serve_idx+1) mod N_PLAYERS, load timer=SERVE_CYC-1.
- PLAY, other inputs:
  - point with point_idx>=N_PLAYERS is dropped, with no state change.
  - If pause=1 with no valid point, go to PAUSED.
  - If pause and a valid point arrive together, the point wins. pause is re-evaluated in the next state.
- PAUSED: pause=0 returns to PLAY. point and start are ignored, and launch is not re-issued.
- OVER: scores and winner hold. On start, go to SERVE with scores cleared, serve_idx=0, winner_valid=0, timer loaded.
- start is ignored in SERVE, PLAY and PAUSED.
- Win condition (base): new score >= WIN_SCORE.
- Illegal state encodings (5..7) return to SPLASH on the next clock.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- point sampled at edge k: scores, state and serve_idx are updated after edge k (one-cycle latency).
- SERVE dwell is exactly SERVE_CYC cycles, counted from the cycle state=SERVE until the cycle before state=PLAY.
- launch is high for exactly the one cycle in which state first reads PLAY after SERVE.
- start at edge k: state=SERVE after edge k.
- Reset (clr_n=0, applied asynchronously), all outputs and internal registers:
  - state=SPLASH, scores=0, serve_idx=0, winner=0, winner_valid=0, launch=0, timer=0.
- Reset release is synchronous to clk (two-flop deassertion synchroniser inside the block).
- Reset mid-serve or mid-play aborts immediately. No partial score is retained.

## Configuration
- Macro MATCH_WIN_BY_TWO_EN.
- Defined: the win condition additionally requires the new score >= every other player's score + 2. A player whose score saturates at 2^SCORE_W-1 wins outright, regardless of lead.
- Undefined: the base win condition only. The comparison logic is compiled out.

## Test plan
- Reset then start, SERVE_CYC=4: state=1 for 4 cycles, then state=2 with launch=1 for one cycle. scores=0, serve_idx=0.
- N_PLAYERS=2, WIN_SCORE=5, five points to idx 1 with a serve between each:
  - scores[1] steps 1..5 and serve_idx alternates.
  - After the fifth point: state=4, winner=1, winner_valid=1.
  - start then gives state=1 and scores=0.
- pause asserted in PLAY: state=3. point pulses during pause leave scores unchanged. pause=0 gives state=2 with no launch. pause and point in the same PLAY cycle: score increments and state=1.
- N_PLAYERS=3, point_idx=3 in PLAY: ignored, with scores and state unchanged. point_idx=2 increments scores[2] and serve_idx advances 0->1.
- MATCH_WIN_BY_TWO_EN, WIN_SCORE=5, SCORE_W=3:
  - At 5-4, a point to idx 0 gives 6-4 and OVER with winner=0.
  - At 6-6, a point to idx 1 gives 6-7: saturation, so OVER with winner=1.
  - Without the macro, 5-4 ends the match.
- clr_n pulsed low mid-SERVE: all outputs return to reset values in the same cycle. Normal flow resumes on the next start.
